// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, opcodes and FSM state type for the keypad operand entry block
//
// Contents:
//   KEY_*    5-bit command/operator key codes (hex digits are any code with bit 4 set)
//   opcode_e operator latched for the arithmetic unit
//   state_e  entry FSM states

package keypad_pkg;

    localparam logic [4:0] KEY_BS  = 5'b00001;
    localparam logic [4:0] KEY_MUL = 5'b00010;
    localparam logic [4:0] KEY_SUB = 5'b00011;
    localparam logic [4:0] KEY_EQ  = 5'b00100;
    localparam logic [4:0] KEY_CA  = 5'b01001;
    localparam logic [4:0] KEY_ADD = 5'b01010;
    localparam logic [4:0] KEY_CE  = 5'b01100;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_SUB = 2'b10
    } opcode_e;

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        WAIT    = 2'b10,
        RESULT  = 2'b11
    } state_e;

endpackage

// File: rtl/keypad_operand_entry_if.sv
// rtl/keypad_operand_entry_if.sv - key/result inputs and operand/display outputs of the entry block
//
// Signals:
//   newkey, keycode        one-cycle keypress strobe and key identity
//   result_valid, result   one-cycle result strobe and value from the arithmetic unit
//   entry, digit_count     displayed value and number of digits typed
//   operand_a, operand_b   latched operands
//   opcode, exec           latched operator and one-cycle compute request
//   digit_drop, busy       full-entry digit rejection pulse, waiting-for-result flag
// Modports: master drives keys/results, slave is the entry block.

interface keypad_operand_entry_if #(
    parameter int DIGITS = 4,
    parameter int W      = 4 * DIGITS
);
    localparam int CW = $clog2(DIGITS + 1);

    logic          newkey;
    logic [4:0]    keycode;
    logic          result_valid;
    logic [W-1:0]  result;
    logic [W-1:0]  entry;
    logic [CW-1:0] digit_count;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [1:0]    opcode;
    logic          exec;
    logic          digit_drop;
    logic          busy;

    modport master (
        output newkey, keycode, result_valid, result,
        input  entry, digit_count, operand_a, operand_b, opcode, exec, digit_drop, busy
    );

    modport slave (
        input  newkey, keycode, result_valid, result,
        output entry, digit_count, operand_a, operand_b, opcode, exec, digit_drop, busy
    );

endinterface

// File: rtl/keycode_decoder.sv
// rtl/keycode_decoder.sv - combinational classification of a keypress into digit/operator/command strobes
//
// Ports:
//   i_newkey, i_keycode  keypress strobe and code
//   o_is_hex, o_hex      hex digit strobe and its value
//   o_is_op, o_op        operator strobe and opcode
//   o_is_bs/ca/ce/eq     command strobes
// All strobes are zero when i_newkey is low or the code is unassigned.

module keycode_decoder
    import keypad_pkg::*;
(
    input  logic       i_newkey,
    input  logic [4:0] i_keycode,
    output logic       o_is_hex,
    output logic [3:0] o_hex,
    output logic       o_is_op,
    output opcode_e    o_op,
    output logic       o_is_bs,
    output logic       o_is_ca,
    output logic       o_is_ce,
    output logic       o_is_eq
);

    always_comb begin
        o_is_hex = 1'b0;
        o_hex    = i_keycode[3:0];
        o_is_op  = 1'b0;
        o_op     = OP_ADD;
        o_is_bs  = 1'b0;
        o_is_ca  = 1'b0;
        o_is_ce  = 1'b0;
        o_is_eq  = 1'b0;
        if (i_newkey) begin
            if (i_keycode[4]) begin
                o_is_hex = 1'b1;
            end else begin
                case (i_keycode)
                    KEY_ADD: begin o_is_op = 1'b1; o_op = OP_ADD; end
                    KEY_SUB: begin o_is_op = 1'b1; o_op = OP_SUB; end
                    KEY_MUL: begin o_is_op = 1'b1; o_op = OP_MUL; end
                    KEY_BS:  o_is_bs = 1'b1;
                    KEY_CA:  o_is_ca = 1'b1;
                    KEY_CE:  o_is_ce = 1'b1;
                    KEY_EQ:  o_is_eq = 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_operand_entry.sv
// rtl/keypad_operand_entry.sv - calculator operand entry FSM: digit entry, operator latch, compute request, result chaining
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    keypad_operand_entry_if.slave (keys and results in, entry/operands/opcode/exec/digit_drop/busy out)
// Every output is driven straight from a flop.

module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int W      = 4 * DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    keypad_operand_entry_if.slave bus
);

    localparam int            CW      = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(DIGITS);

    logic          w_is_hex, w_is_op, w_is_bs, w_is_ca, w_is_ce, w_is_eq;
    logic [3:0]    w_hex;
    opcode_e       w_op;

    state_e        r_state,   w_nxt_state;
    logic [W-1:0]  r_entry,   w_nxt_entry;
    logic [CW-1:0] r_cnt,     w_nxt_cnt;
    logic [W-1:0]  r_opa,     w_nxt_opa;
    logic [W-1:0]  r_opb,     w_nxt_opb;
    opcode_e       r_opcode,  w_nxt_opcode;
    logic          r_exec,    w_nxt_exec;
    logic          r_drop,    w_nxt_drop;
    logic          r_busy;

    keycode_decoder u_dec (
        .i_newkey  (bus.newkey),
        .i_keycode (bus.keycode),
        .o_is_hex  (w_is_hex),
        .o_hex     (w_hex),
        .o_is_op   (w_is_op),
        .o_op      (w_op),
        .o_is_bs   (w_is_bs),
        .o_is_ca   (w_is_ca),
        .o_is_ce   (w_is_ce),
        .o_is_eq   (w_is_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ENTER_A;
            r_entry  <= '0;
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_opcode <= OP_ADD;
            r_exec   <= 1'b0;
            r_drop   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_entry  <= w_nxt_entry;
            r_cnt    <= w_nxt_cnt;
            r_opa    <= w_nxt_opa;
            r_opb    <= w_nxt_opb;
            r_opcode <= w_nxt_opcode;
            r_exec   <= w_nxt_exec;
            r_drop   <= w_nxt_drop;
            r_busy   <= (w_nxt_state == WAIT);
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_entry  = r_entry;
        w_nxt_cnt    = r_cnt;
        w_nxt_opa    = r_opa;
        w_nxt_opb    = r_opb;
        w_nxt_opcode = r_opcode;
        w_nxt_exec   = 1'b0;
        w_nxt_drop   = 1'b0;

        if (w_is_ca) begin
            // Clear-all wins over everything, including a result arriving in the same cycle.
            w_nxt_state  = ENTER_A;
            w_nxt_entry  = '0;
            w_nxt_cnt    = '0;
            w_nxt_opa    = '0;
            w_nxt_opb    = '0;
            w_nxt_opcode = OP_ADD;
        end else begin
            case (r_state)
                ENTER_A, ENTER_B: begin
                    if (w_is_hex) begin
                        if (r_cnt < MAX_CNT) begin
                            w_nxt_entry = (r_entry << 4) | W'(w_hex);
                            w_nxt_cnt   = r_cnt + 1'b1;
                        end else begin
                            w_nxt_drop = 1'b1;
                        end
                    end else if (w_is_bs) begin
                        if (r_cnt != '0) begin
                            w_nxt_entry = r_entry >> 4;
                            w_nxt_cnt   = r_cnt - 1'b1;
                        end
                    end else if (w_is_ce) begin
                        w_nxt_entry = '0;
                        w_nxt_cnt   = '0;
                    end else if (w_is_op) begin
                        if (r_state == ENTER_A) begin
                            w_nxt_opa    = r_entry;
                            w_nxt_opcode = w_op;
                            w_nxt_entry  = '0;
                            w_nxt_cnt    = '0;
                            w_nxt_state  = ENTER_B;
                        end else if (r_cnt == '0) begin
                            // No second operand typed yet: the user is changing the operator.
                            w_nxt_opcode = w_op;
                        end
                    end else if (w_is_eq) begin
                        if (r_state == ENTER_B && r_cnt != '0) begin
                            w_nxt_opb   = r_entry;
                            w_nxt_exec  = 1'b1;
                            w_nxt_state = WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Any non-CA key in this state is dropped, even alongside a result.
                    if (bus.result_valid) begin
                        w_nxt_entry = bus.result;
                        w_nxt_opa   = bus.result;
                        w_nxt_cnt   = '0;
                        w_nxt_state = RESULT;
                    end
                end
                RESULT: begin
                    if (w_is_hex) begin
                        w_nxt_entry = W'(w_hex);
                        w_nxt_cnt   = CW'(1);
                        w_nxt_state = ENTER_A;
                    end else if (w_is_op) begin
                        // operand_a already holds the result, so the next op chains on it.
                        w_nxt_opcode = w_op;
                        w_nxt_entry  = '0;
                        w_nxt_cnt    = '0;
                        w_nxt_state  = ENTER_B;
                    end else if (w_is_bs || w_is_ce) begin
                        w_nxt_entry = '0;
                        w_nxt_cnt   = '0;
                        w_nxt_state = ENTER_A;
                    end
                end
                default: w_nxt_state = ENTER_A;
            endcase
        end
    end

    assign bus.entry       = r_entry;
    assign bus.digit_count = r_cnt;
    assign bus.operand_a   = r_opa;
    assign bus.operand_b   = r_opb;
    assign bus.opcode      = r_opcode;
    assign bus.exec        = r_exec;
    assign bus.digit_drop  = r_drop;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// tb/tb_keypad_operand_entry.sv - scoreboard bench for keypad_operand_entry with DIGITS=4

module tb_keypad_operand_entry;
    import keypad_pkg::*;

    typedef struct packed {
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic [15:0] opa;
        logic [15:0] opb;
        logic [1:0]  opc;
        logic        ex;
        logic        dr;
        logic        bz;
    } snap_t;

    typedef struct {
        string name;
        snap_t exp;
    } item_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   n_exec_seen;
    int   n_drop_seen;
    logic seen_strobe;
    item_t sb[$];

    keypad_operand_entry_if #(.DIGITS(4)) bus ();

    keypad_operand_entry #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t mk(logic [15:0] en, logic [2:0] c, logic [15:0] a, logic [15:0] b,
                                 logic [1:0] opc, logic ex, logic dr, logic bz);
        snap_t s;
        s.entry = en; s.cnt = c; s.opa = a; s.opb = b; s.opc = opc; s.ex = ex; s.dr = dr; s.bz = bz;
        return s;
    endfunction

    function automatic snap_t get_snap();
        return mk(bus.entry, bus.digit_count, bus.operand_a, bus.operand_b,
                  bus.opcode, bus.exec, bus.digit_drop, bus.busy);
    endfunction

    task automatic check(string name, snap_t act, snap_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got entry=%h cnt=%0d a=%h b=%h op=%0d exec=%0b drop=%0b busy=%0b, expected entry=%h cnt=%0d a=%h b=%h op=%0d exec=%0b drop=%0b busy=%0b",
                     name, act.entry, act.cnt, act.opa, act.opb, act.opc, act.ex, act.dr, act.bz,
                     exp.entry, exp.cnt, exp.opa, exp.opb, exp.opc, exp.ex, exp.dr, exp.bz);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one strobe cycle; its expected outcome is queued for the monitor.
    task automatic strobe(logic nk, logic [4:0] kc, logic rv, logic [15:0] res, string name, snap_t e);
        item_t it;
        @(posedge clk);
        #1;
        bus.newkey       = nk;
        bus.keycode      = kc;
        bus.result_valid = rv;
        bus.result       = res;
        it.name = name;
        it.exp  = e;
        sb.push_back(it);
        @(posedge clk);
        #1;
        bus.newkey       = 1'b0;
        bus.result_valid = 1'b0;
        bus.keycode      = 5'b00000;
    endtask

    task automatic key(logic [4:0] kc, string name, snap_t e);
        strobe(1'b1, kc, 1'b0, 16'h0000, name, e);
    endtask

    task automatic res(logic [15:0] r, string name, snap_t e);
        strobe(1'b0, 5'b00000, 1'b1, r, name, e);
    endtask

    function automatic logic [4:0] hx(int d);
        return 5'h10 | 5'(d);
    endfunction

    task automatic mid_cycle_reset(string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check(name, get_snap(), mk(16'h0, 3'd0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: any input strobe seen at a rising edge produces one expected outcome.
    always @(posedge clk) begin
        seen_strobe <= rst_n && (bus.newkey || bus.result_valid);
    end

    always @(negedge clk) begin
        item_t it;
        if (bus.exec === 1'b1)       n_exec_seen++;
        if (bus.digit_drop === 1'b1) n_drop_seen++;
        if (seen_strobe === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL monitor: output cycle with empty scoreboard");
            end else begin
                it = sb.pop_front();
                check(it.name, get_snap(), it.exp);
            end
        end
    end

    initial begin
        n_checks = 0; n_errors = 0; n_exec_seen = 0; n_drop_seen = 0;
        seen_strobe = 1'b0;
        rst_n = 1'b0;
        bus.newkey = 1'b0; bus.keycode = 5'b00000; bus.result_valid = 1'b0; bus.result = 16'h0000;
        #12;
        check("reset_asserted", get_snap(), mk(16'h0, 3'd0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_released", get_snap(), mk(16'h0, 3'd0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 1'b0));

        // digits and backspace
        key(hx(1), "d1",   mk(16'h0001, 3'd1, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(hx(2), "d12",  mk(16'h0012, 3'd2, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(hx(3), "d123", mk(16'h0123, 3'd3, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(KEY_BS, "bs",  mk(16'h0012, 3'd2, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(KEY_CA, "ca1", mk(16'h0000, 3'd0, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(KEY_BS, "bs_empty", mk(16'h0000, 3'd0, 16'h0, 16'h0, 2'b00, 0, 0, 0));

        // full entry and dropped fifth digit
        key(hx(1), "f1", mk(16'h0001, 3'd1, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(hx(2), "f2", mk(16'h0012, 3'd2, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(hx(3), "f3", mk(16'h0123, 3'd3, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(hx(4), "f4", mk(16'h1234, 3'd4, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(hx(5), "f5_drop", mk(16'h1234, 3'd4, 16'h0, 16'h0, 2'b00, 0, 1, 0));
        key(KEY_EQ, "eq_in_a", mk(16'h1234, 3'd4, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(5'b00111, "unassigned", mk(16'h1234, 3'd4, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(KEY_CA, "ca2", mk(16'h0000, 3'd0, 16'h0, 16'h0, 2'b00, 0, 0, 0));

        // 12 + 34
        key(hx(1), "a1", mk(16'h0001, 3'd1, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(hx(2), "a2", mk(16'h0012, 3'd2, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(KEY_ADD, "add", mk(16'h0000, 3'd0, 16'h0012, 16'h0, 2'b00, 0, 0, 0));
        key(KEY_EQ, "eq_b_empty", mk(16'h0000, 3'd0, 16'h0012, 16'h0, 2'b00, 0, 0, 0));
        key(hx(3), "b3", mk(16'h0003, 3'd1, 16'h0012, 16'h0, 2'b00, 0, 0, 0));
        key(hx(4), "b4", mk(16'h0034, 3'd2, 16'h0012, 16'h0, 2'b00, 0, 0, 0));
        key(KEY_EQ, "eq_exec", mk(16'h0034, 3'd2, 16'h0012, 16'h0034, 2'b00, 1, 0, 1));
        key(hx(7), "wait_key", mk(16'h0034, 3'd2, 16'h0012, 16'h0034, 2'b00, 0, 0, 1));
        res(16'h0046, "result46", mk(16'h0046, 3'd0, 16'h0046, 16'h0034, 2'b00, 0, 0, 0));
        key(KEY_SUB, "chain_sub", mk(16'h0000, 3'd0, 16'h0046, 16'h0034, 2'b10, 0, 0, 0));
        key(KEY_MUL, "op_replace", mk(16'h0000, 3'd0, 16'h0046, 16'h0034, 2'b01, 0, 0, 0));
        key(hx(9), "b9", mk(16'h0009, 3'd1, 16'h0046, 16'h0034, 2'b01, 0, 0, 0));
        key(KEY_ADD, "op_ignored", mk(16'h0009, 3'd1, 16'h0046, 16'h0034, 2'b01, 0, 0, 0));
        key(KEY_EQ, "eq_exec2", mk(16'h0009, 3'd1, 16'h0046, 16'h0009, 2'b01, 1, 0, 1));
        strobe(1'b1, hx(5), 1'b1, 16'h0AAA, "result_and_key",
               mk(16'h0AAA, 3'd0, 16'h0AAA, 16'h0009, 2'b01, 0, 0, 0));
        key(KEY_EQ, "eq_in_result", mk(16'h0AAA, 3'd0, 16'h0AAA, 16'h0009, 2'b01, 0, 0, 0));
        key(hx(7), "result_digit", mk(16'h0007, 3'd1, 16'h0AAA, 16'h0009, 2'b01, 0, 0, 0));
        key(KEY_CE, "ce", mk(16'h0000, 3'd0, 16'h0AAA, 16'h0009, 2'b01, 0, 0, 0));
        key(hx(2), "c2", mk(16'h0002, 3'd1, 16'h0AAA, 16'h0009, 2'b01, 0, 0, 0));
        key(KEY_ADD, "add2", mk(16'h0000, 3'd0, 16'h0002, 16'h0009, 2'b00, 0, 0, 0));
        key(hx(3), "c3", mk(16'h0003, 3'd1, 16'h0002, 16'h0009, 2'b00, 0, 0, 0));
        key(KEY_EQ, "eq_exec3", mk(16'h0003, 3'd1, 16'h0002, 16'h0003, 2'b00, 1, 0, 1));
        key(KEY_CA, "ca_in_wait", mk(16'h0000, 3'd0, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        res(16'hBEEF, "late_result", mk(16'h0000, 3'd0, 16'h0, 16'h0, 2'b00, 0, 0, 0));

        // asynchronous reset in ENTER_B
        key(hx(1), "r1", mk(16'h0001, 3'd1, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(KEY_ADD, "radd", mk(16'h0000, 3'd0, 16'h0001, 16'h0, 2'b00, 0, 0, 0));
        key(hx(5), "r5", mk(16'h0005, 3'd1, 16'h0001, 16'h0, 2'b00, 0, 0, 0));
        mid_cycle_reset("async_reset_enter_b");
        key(KEY_EQ, "eq_after_reset", mk(16'h0000, 3'd0, 16'h0, 16'h0, 2'b00, 0, 0, 0));

        // asynchronous reset in WAIT
        key(hx(1), "w1", mk(16'h0001, 3'd1, 16'h0, 16'h0, 2'b00, 0, 0, 0));
        key(KEY_ADD, "wadd", mk(16'h0000, 3'd0, 16'h0001, 16'h0, 2'b00, 0, 0, 0));
        key(hx(2), "w2", mk(16'h0002, 3'd1, 16'h0001, 16'h0, 2'b00, 0, 0, 0));
        key(KEY_EQ, "eq_exec4", mk(16'h0002, 3'd1, 16'h0001, 16'h0002, 2'b00, 1, 0, 1));
        mid_cycle_reset("async_reset_wait");
        res(16'h1111, "result_after_reset", mk(16'h0000, 3'd0, 16'h0, 16'h0, 2'b00, 0, 0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_int("scoreboard_drained", sb.size(), 0);
        check_int("exec_pulses", n_exec_seen, 4);
        check_int("drop_pulses", n_drop_seen, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
